// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, FSM states and search-range helper for the FFT bin stream blocks
package fft_pkg;
  localparam int DATA_W = 4;
  localparam int N_BINS = 32;
  localparam int BIN_W = $clog2(N_BINS);
  localparam int MAG_W = 2 * DATA_W;
  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
  function automatic logic in_range(input logic [BIN_W-1:0] idx, input logic skip_dc, input logic half);
    return (idx != '0 || !skip_dc) && (!half || idx < BIN_W'(N_BINS / 2));
  endfunction
endpackage

// File: rtl/fft_mag_sq.sv
// fft_mag_sq: registered magnitude-squared of one complex bin with valid/index pass-through
module fft_mag_sq
  import fft_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [BIN_W-1:0]         i_idx,
  input  logic signed [DATA_W-1:0] i_re,
  input  logic signed [DATA_W-1:0] i_im,
  output logic                     o_valid,
  output logic [BIN_W-1:0]         o_idx,
  output logic [MAG_W-1:0]         o_mag
);
  logic signed [MAG_W-1:0] w_re, w_im;
  logic [MAG_W-1:0] w_re_sq, w_im_sq;
  assign w_re = {{(MAG_W-DATA_W){i_re[DATA_W-1]}}, i_re};
  assign w_im = {{(MAG_W-DATA_W){i_im[DATA_W-1]}}, i_im};
  // Squares are taken at full MAG_W so (-8)^2+(-8)^2 = 128 wraps into the unsigned range intact
  assign w_re_sq = w_re * w_re;
  assign w_im_sq = w_im * w_im;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_idx <= '0;
      o_mag <= '0;
    end else begin
      o_valid <= i_valid;
      o_idx <= i_idx;
      o_mag <= w_re_sq + w_im_sq;
    end
endmodule

// File: rtl/fft_peak_bin_finder.sv
// fft_peak_bin_finder: tracks the strongest in-range bin of each FFT frame and reports it once per frame
module fft_peak_bin_finder
  import fft_pkg::*;
#(
  parameter bit SKIP_DC = 1'b1,
  parameter bit SEARCH_HALF = 1'b1
) (
  input  logic                     dut_clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     bin_valid,
  input  logic signed [DATA_W-1:0] bin_real,
  input  logic signed [DATA_W-1:0] bin_imag,
  input  logic [MAG_W-1:0]         thresh,
  output logic [BIN_W-1:0]         peak_bin,
  output logic [MAG_W-1:0]         peak_mag,
  output logic                     peak_valid,
  output logic                     peak_found,
  output logic                     busy,
  output logic                     frame_err
);
  localparam logic [BIN_W-1:0] FIRST_BIN = BIN_W'(SKIP_DC);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_BINS - 1);
  state_t r_state, w_next;
  logic [BIN_W-1:0] r_cnt, r_max_idx, w_s1_idx;
  logic [MAG_W-1:0] r_max, w_s1_mag;
  logic r_done, w_s1_valid, w_accept, w_abort, w_drained;
  assign w_accept = r_state == ACCUM && !r_done && bin_valid && !frame_start;
  assign w_abort = frame_start && r_state == ACCUM;
  assign w_drained = r_done && !w_s1_valid;
  // A frame_start bin is always bin 0; its load also overwrites any stale stage-1 entry
  fft_mag_sq u_mag (
    .i_clk(dut_clk),
    .i_rst_n(reset),
    .i_valid(w_accept || (frame_start && bin_valid)),
    .i_idx(frame_start ? '0 : r_cnt),
    .i_re(bin_real),
    .i_im(bin_imag),
    .o_valid(w_s1_valid),
    .o_idx(w_s1_idx),
    .o_mag(w_s1_mag)
  );
  always_ff @(posedge dut_clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    busy = r_state == ACCUM;
    peak_valid = r_state == REPORT;
    w_next = frame_start ? ACCUM :
             (r_state == ACCUM && w_drained) ? REPORT :
             (r_state == REPORT) ? IDLE : r_state;
  end
  always_ff @(posedge dut_clk or negedge reset)
    if (!reset) begin
      r_cnt <= '0;
      r_done <= 1'b0;
      r_max <= '0;
      r_max_idx <= '0;
      peak_bin <= '0;
      peak_mag <= '0;
      peak_found <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= w_abort;
      if (frame_start) begin
        r_cnt <= BIN_W'(bin_valid);
        r_done <= 1'b0;
        r_max <= '0;
        r_max_idx <= FIRST_BIN;
      end else begin
        if (w_accept) begin
          r_done <= r_cnt == LAST_BIN;
          r_cnt <= (r_cnt == LAST_BIN) ? r_cnt : r_cnt + 1'b1;
        end
        // Strict compare over increasing indices keeps the lowest index on ties
        if (w_s1_valid && in_range(w_s1_idx, SKIP_DC, SEARCH_HALF) && w_s1_mag > r_max) begin
          r_max <= w_s1_mag;
          r_max_idx <= w_s1_idx;
        end
      end
      if (w_next == REPORT) begin
        peak_bin <= r_max_idx;
        peak_mag <= r_max;
        peak_found <= r_max >= thresh;
      end
    end
endmodule

// File: tb/tb_fft_peak_bin_finder.sv
// tb_fft_peak_bin_finder: scoreboard bench comparing peak reports against a frame-level reference model
module tb_fft_peak_bin_finder;
  import fft_pkg::*;
  logic dut_clk = 1'b0, reset = 1'b0, frame_start = 1'b0, bin_valid = 1'b0;
  logic signed [DATA_W-1:0] bin_real = '0, bin_imag = '0;
  logic [MAG_W-1:0] thresh = '0;
  logic [BIN_W-1:0] peak_bin;
  logic [MAG_W-1:0] peak_mag;
  logic peak_valid, peak_found, busy, frame_err;
  int checks = 0, errors = 0, edges = 0;
  bit in_frame = 1'b0;
  typedef struct {int bin; int mag; bit found; int at;} exp_t;
  exp_t peak_q[$];
  exp_t mon_e;
  int err_q[$];
  int mon_at;
  int fr_re[N_BINS], fr_im[N_BINS];

  fft_peak_bin_finder dut (
    .dut_clk(dut_clk), .reset(reset), .frame_start(frame_start), .bin_valid(bin_valid),
    .bin_real(bin_real), .bin_imag(bin_imag), .thresh(thresh), .peak_bin(peak_bin),
    .peak_mag(peak_mag), .peak_valid(peak_valid), .peak_found(peak_found), .busy(busy),
    .frame_err(frame_err)
  );

  always #5 dut_clk = ~dut_clk;
  always @(posedge dut_clk) edges++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: strongest bin among 1..N_BINS/2-1, first occurrence wins, default is the lowest searched bin
  function automatic exp_t ref_peak(input int at);
    exp_t e;
    e.bin = 1;
    e.mag = 0;
    for (int i = 1; i < N_BINS / 2; i++) begin
      int m;
      m = fr_re[i] * fr_re[i] + fr_im[i] * fr_im[i];
      if (m > e.mag) begin
        e.mag = m;
        e.bin = i;
      end
    end
    e.found = e.mag >= int'(thresh);
    e.at = at;
    return e;
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < N_BINS; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
  endtask

  task automatic random_frame();
    for (int i = 0; i < N_BINS; i++) begin
      fr_re[i] = int'($urandom_range(15)) - 8;
      fr_im[i] = int'($urandom_range(15)) - 8;
    end
  endtask

  task automatic send_frame(input int gap, input int stop_at);
    int last;
    last = 0;
    for (int i = 0; i < N_BINS; i++) begin
      if (i == stop_at) begin
        frame_start = 1'b0;
        bin_valid = 1'b0;
        return;
      end
      while (i > 0 && int'($urandom_range(99)) < gap) begin
        frame_start = 1'b0;
        bin_valid = 1'b0;
        bin_real = DATA_W'($urandom);
        bin_imag = DATA_W'($urandom);
        @(posedge dut_clk); #1;
        check("busy_gap", busy, 1);
      end
      frame_start = i == 0;
      bin_valid = 1'b1;
      bin_real = DATA_W'(fr_re[i]);
      bin_imag = DATA_W'(fr_im[i]);
      @(posedge dut_clk); #1;
      if (i == 0 && in_frame) err_q.push_back(edges);
      in_frame = 1'b1;
      last = edges;
      check("busy", busy, 1);
    end
    peak_q.push_back(ref_peak(last + 2));
    frame_start = 1'b0;
    repeat (2) begin
      bin_valid = 1'($urandom);
      bin_real = DATA_W'($urandom);
      bin_imag = DATA_W'($urandom);
      @(posedge dut_clk); #1;
    end
    check("busy_report", busy, 0);
    bin_valid = 1'b0;
    in_frame = 1'b0;
  endtask

  always @(negedge dut_clk) if (reset) begin
    if (peak_valid) begin
      if (peak_q.size() == 0) check("unexpected_peak_valid", 1, 0);
      else begin
        mon_e = peak_q.pop_front();
        check("peak_bin", int'(peak_bin), mon_e.bin);
        check("peak_mag", int'(peak_mag), mon_e.mag);
        check("peak_found", int'(peak_found), int'(mon_e.found));
        check("peak_latency", edges, mon_e.at);
      end
    end
    if (frame_err) begin
      if (err_q.size() == 0) check("unexpected_frame_err", 1, 0);
      else begin
        mon_at = err_q.pop_front();
        check("frame_err_time", edges, mon_at);
      end
    end
  end

  initial begin
    repeat (5) begin
      frame_start = 1'($urandom);
      bin_valid = 1'($urandom);
      bin_real = DATA_W'($urandom);
      bin_imag = DATA_W'($urandom);
      thresh = MAG_W'($urandom);
      @(negedge dut_clk);
      check("rst_peak_valid", int'(peak_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_frame_err", int'(frame_err), 0);
      check("rst_peak_bin", int'(peak_bin), 0);
      check("rst_peak_mag", int'(peak_mag), 0);
      check("rst_peak_found", int'(peak_found), 0);
    end
    frame_start = 1'b0;
    bin_valid = 1'b0;
    @(posedge dut_clk); #1;
    reset = 1'b1;
    repeat (6) begin
      bin_valid = 1'($urandom);
      bin_real = DATA_W'($urandom);
      bin_imag = DATA_W'($urandom);
      @(posedge dut_clk); #1;
      check("idle_busy", int'(busy), 0);
      check("idle_peak_valid", int'(peak_valid), 0);
    end
    bin_valid = 1'b0;
    clear_frame();
    fr_re[5] = 3; fr_im[5] = -4;
    thresh = 16;
    send_frame(0, -1);
    repeat (3) @(posedge dut_clk);
    #1;
    clear_frame();
    fr_re[0] = -8; fr_im[0] = -8;
    fr_re[3] = 7;
    fr_im[9] = -7;
    fr_re[20] = -8; fr_im[20] = -8;
    thresh = 40;
    send_frame(0, -1);
    thresh = 50;
    send_frame(0, -1);
    clear_frame();
    fr_re[5] = 3; fr_im[5] = -4;
    thresh = 16;
    send_frame(50, -1);
    random_frame();
    send_frame(0, 10);
    clear_frame();
    fr_re[12] = 5; fr_im[12] = 5;
    thresh = 50;
    send_frame(0, -1);
    random_frame();
    send_frame(0, 20);
    #3 reset = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_peak_bin", int'(peak_bin), 0);
    check("arst_peak_mag", int'(peak_mag), 0);
    check("arst_peak_found", int'(peak_found), 0);
    in_frame = 1'b0;
    @(posedge dut_clk); #1;
    reset = 1'b1;
    clear_frame();
    fr_re[7] = 6; fr_im[7] = 1;
    thresh = MAG_W'($urandom_range(60));
    send_frame(0, -1);
    clear_frame();
    thresh = 0;
    send_frame(0, -1);
    repeat (8) begin
      random_frame();
      thresh = MAG_W'($urandom_range(128));
      send_frame(int'($urandom_range(60)), -1);
      repeat ($urandom_range(2)) @(posedge dut_clk);
      #1;
    end
    repeat (5) @(posedge dut_clk);
    #1;
    check("peak_q_drained", peak_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
